// File: rtl/vga_pkg.sv
// vga_pkg: shared raster geometry and stage-to-stage bus for the video
// pipeline (800x600@60, 40 MHz pixel clock).
//   HOR_*/VER_*        : visible size, sync window [START, END) and totals
//   HCNT_W / VCNT_W    : counter widths (enough for 1055 / 627)
//   vga_if_t           : position + sync/blank bundle passed between stages
package vga_pkg;

  localparam int unsigned HOR_PIXELS     = 800;
  localparam int unsigned HOR_SYNC_START = 840;
  localparam int unsigned HOR_SYNC_END   = 968;   // exclusive
  localparam int unsigned HOR_TOT_PIX    = 1056;

  localparam int unsigned VER_PIXELS     = 600;
  localparam int unsigned VER_SYNC_START = 601;
  localparam int unsigned VER_SYNC_END   = 605;   // exclusive
  localparam int unsigned VER_TOT_PIX    = 628;

  localparam int unsigned HCNT_W = 11;
  localparam int unsigned VCNT_W = 11;

  typedef struct packed {
    logic [VCNT_W-1:0] vcount;
    logic              vsync;
    logic              vblnk;
    logic [HCNT_W-1:0] hcount;
    logic              hsync;
    logic              hblnk;
  } vga_if_t;

endpackage

// File: rtl/vga_timing.sv
// vga_timing: raster timing generator. Free-running horizontal/vertical
// counters with registered sync, blanking, line/frame markers and a frame
// counter. Every output is derived from the *next* counter values, so flags
// always line up with the hcount/vcount shown in the same cycle.
//
// Ports:
//   clk          pixel clock
//   rst_n        asynchronous active-low reset
//   en           pixel advance enable; raster freezes while low
//   hcount       horizontal position 0..H_TOTAL-1
//   vcount       vertical position 0..V_TOTAL-1
//   hsync/vsync  sync pulses, active level HSYNC_POL/VSYNC_POL
//   hblnk/vblnk  high outside the visible area
//   line_start   one-cycle pulse when hcount wraps to 0
//   frame_start  one-cycle pulse when both counters wrap to 0
//   frame_cnt    completed frames, wraps modulo 2^FRAME_CNT_W
//
// The geometry parameters default to the 800x600 timing; they exist so a
// shrunken raster can be elaborated without touching the counter logic.
module vga_timing
  import vga_pkg::*;
#(
  parameter logic        HSYNC_POL      = 1'b1,
  parameter logic        VSYNC_POL      = 1'b1,
  parameter int unsigned FRAME_CNT_W    = 16,
  parameter int unsigned H_PIXELS       = HOR_PIXELS,
  parameter int unsigned H_SYNC_START   = HOR_SYNC_START,
  parameter int unsigned H_SYNC_END     = HOR_SYNC_END,
  parameter int unsigned H_TOTAL        = HOR_TOT_PIX,
  parameter int unsigned V_PIXELS       = VER_PIXELS,
  parameter int unsigned V_SYNC_START   = VER_SYNC_START,
  parameter int unsigned V_SYNC_END     = VER_SYNC_END,
  parameter int unsigned V_TOTAL        = VER_TOT_PIX
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  output logic [HCNT_W-1:0]      hcount,
  output logic [VCNT_W-1:0]      vcount,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   hblnk,
  output logic                   vblnk,
  output logic                   line_start,
  output logic                   frame_start,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam logic [HCNT_W-1:0] H_LAST  = HCNT_W'(H_TOTAL - 1);
  localparam logic [VCNT_W-1:0] V_LAST  = VCNT_W'(V_TOTAL - 1);
  localparam logic [HCNT_W-1:0] H_VIS   = HCNT_W'(H_PIXELS);
  localparam logic [VCNT_W-1:0] V_VIS   = VCNT_W'(V_PIXELS);
  localparam logic [HCNT_W-1:0] H_SS    = HCNT_W'(H_SYNC_START);
  localparam logic [HCNT_W-1:0] H_SE    = HCNT_W'(H_SYNC_END);
  localparam logic [VCNT_W-1:0] V_SS    = VCNT_W'(V_SYNC_START);
  localparam logic [VCNT_W-1:0] V_SE    = VCNT_W'(V_SYNC_END);

  logic [HCNT_W-1:0]      hcount_nxt;
  logic [VCNT_W-1:0]      vcount_nxt;
  logic [FRAME_CNT_W-1:0] frame_cnt_nxt;
  logic                   hsync_nxt, vsync_nxt, hblnk_nxt, vblnk_nxt;
  logic                   line_start_nxt, frame_start_nxt;

  // NOTE: every variable gets a default before any branch, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    hcount_nxt      = hcount;
    vcount_nxt      = vcount;
    frame_cnt_nxt   = frame_cnt;
    line_start_nxt  = 1'b0;   // pulses drop while stalled, never stretch
    frame_start_nxt = 1'b0;

    if (en) begin
      if (hcount == H_LAST) begin
        hcount_nxt     = '0;
        line_start_nxt = 1'b1;
        if (vcount == V_LAST) begin
          vcount_nxt      = '0;
          frame_cnt_nxt   = frame_cnt + FRAME_CNT_W'(1);
          frame_start_nxt = 1'b1;
        end else begin
          vcount_nxt = vcount + VCNT_W'(1);
        end
      end else begin
        hcount_nxt = hcount + HCNT_W'(1);
      end
    end

    // Flags follow the next counter values, giving zero skew once registered.
    // vsync looks at vcount only, so it can change only at a line wrap.
    hsync_nxt = ((hcount_nxt >= H_SS) && (hcount_nxt < H_SE)) ? HSYNC_POL : ~HSYNC_POL;
    vsync_nxt = ((vcount_nxt >= V_SS) && (vcount_nxt < V_SE)) ? VSYNC_POL : ~VSYNC_POL;
    hblnk_nxt = (hcount_nxt >= H_VIS);
    vblnk_nxt = (vcount_nxt >= V_VIS);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values sampled before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount      <= '0;
      vcount      <= '0;
      frame_cnt   <= '0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hcount      <= hcount_nxt;
      vcount      <= vcount_nxt;
      frame_cnt   <= frame_cnt_nxt;
      hsync       <= hsync_nxt;
      vsync       <= vsync_nxt;
      hblnk       <= hblnk_nxt;
      vblnk       <= vblnk_nxt;
      line_start  <= line_start_nxt;
      frame_start <= frame_start_nxt;
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: two instances on one clock.
//   dut_a : full 800x600 geometry, default polarities, 16-bit frame counter
//   dut_b : shrunken 40x20 raster, active-low syncs, 2-bit frame counter,
//           so frame wraps and frame-counter wraps happen within a short run
// The reference model maps the number of enabled edges since reset straight
// to a raster position with div/mod and derives all flags from that.
module tb_vga_timing;

  // Shrunken geometry for dut_b
  localparam int B_HP = 24, B_HSS = 28, B_HSE = 32, B_HT = 40;
  localparam int B_VP = 12, B_VSS = 13, B_VSE = 15, B_VT = 20;
  localparam int B_FRAME = B_HT * B_VT;

  logic clk;
  logic rst_a, rst_b, en_a, en_b;

  logic [10:0] hc_a, vc_a, hc_b, vc_b;
  logic hs_a, vs_a, hb_a, vb_a, ls_a, fs_a;
  logic hs_b, vs_b, hb_b, vb_b, ls_b, fs_b;
  logic [15:0] fc_a;
  logic [1:0]  fc_b;

  int n_cmp = 0;
  int n_bad = 0;

  longint t_a, t_b;        // enabled edges since last reset release
  bit     last_a, last_b;  // previous edge was an enabled, running edge

  vga_timing dut_a (
    .clk(clk), .rst_n(rst_a), .en(en_a),
    .hcount(hc_a), .vcount(vc_a), .hsync(hs_a), .vsync(vs_a),
    .hblnk(hb_a), .vblnk(vb_a), .line_start(ls_a), .frame_start(fs_a),
    .frame_cnt(fc_a)
  );

  vga_timing #(
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .FRAME_CNT_W(2),
    .H_PIXELS(B_HP), .H_SYNC_START(B_HSS), .H_SYNC_END(B_HSE), .H_TOTAL(B_HT),
    .V_PIXELS(B_VP), .V_SYNC_START(B_VSS), .V_SYNC_END(B_VSE), .V_TOTAL(B_VT)
  ) dut_b (
    .clk(clk), .rst_n(rst_b), .en(en_b),
    .hcount(hc_b), .vcount(vc_b), .hsync(hs_b), .vsync(vs_b),
    .hblnk(hb_b), .vblnk(vb_b), .line_start(ls_b), .frame_start(fs_b),
    .frame_cnt(fc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs packed as {pad, frame_cnt16, ls, fs, vblnk, hblnk, vsync, hsync, v, h}
  logic [47:0] obs_a, obs_b;
  assign obs_a = {4'b0, fc_a, ls_a, fs_a, vb_a, hb_a, vs_a, hs_a, vc_a, hc_a};
  assign obs_b = {4'b0, 14'b0, fc_b, ls_b, fs_b, vb_b, hb_b, vs_b, hs_b, vc_b, hc_b};

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [47:0] ref_out(input longint t, input bit pulse,
      input int ht, input int hp, input int hss, input int hse,
      input int vt, input int vp, input int vss, input int vse,
      input bit hpol, input bit vpol, input int fw);
    longint pos = t % (ht * vt);
    int     h   = int'(pos % ht);
    int     v   = int'(pos / ht);
    longint fc  = (t / (ht * vt)) % (longint'(1) << fw);
    bit     hs  = (h >= hss && h < hse) ? hpol : !hpol;
    bit     vs  = (v >= vss && v < vse) ? vpol : !vpol;
    bit     ls  = pulse && (h == 0);
    bit     fs  = pulse && (h == 0) && (v == 0);
    return {4'b0, 16'(fc), ls, fs, (v >= vp), (h >= hp), vs, hs, 11'(v), 11'(h)};
  endfunction

  function automatic logic [47:0] model_a();
    return ref_out(t_a, last_a, 1056, 800, 840, 968, 628, 600, 601, 605, 1'b1, 1'b1, 16);
  endfunction

  function automatic logic [47:0] model_b();
    return ref_out(t_b, last_b, B_HT, B_HP, B_HSS, B_HSE, B_VT, B_VP, B_VSS, B_VSE,
                   1'b0, 1'b0, 2);
  endfunction

  // One clock: drive enables on the falling edge, advance the model on the
  // rising edge, compare both instances 1 ns later.
  task automatic step(input logic ea, input logic eb);
    @(negedge clk);
    en_a = ea;
    en_b = eb;
    @(posedge clk);
    if (rst_a && ea) t_a++;
    if (rst_b && eb) t_b++;
    last_a = rst_a && ea;
    last_b = rst_b && eb;
    #1;
    check("a_cycle", obs_a, model_a());
    check("b_cycle", obs_b, model_b());
  endtask

  initial begin
    int cnt;
    int vs_cnt, vb_cnt, hs_cnt;
    bit saw_wrap;
    logic [1:0] prev_fc;
    logic [47:0] held;

    rst_a = 1'b0; rst_b = 1'b0; en_a = 1'b0; en_b = 1'b0;
    t_a = 0; t_b = 0; last_a = 0; last_b = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("a_reset", obs_a, model_a());
    check("b_reset", obs_b, model_b());
    check("b_reset_syncs_inactive_high", {46'b0, vs_b, hs_b}, 48'h3);
    check("a_reset_syncs_inactive_low", {46'b0, vs_a, hs_a}, 48'h0);

    @(negedge clk);
    rst_a = 1'b1;
    rst_b = 1'b1;

    // Full-size raster, continuously enabled, over 7 lines; dut_b random en.
    for (int c = 1; c <= 7 * 1056 + 400; c++) begin
      step(1'b1, $urandom_range(3) != 0);
      if (c == 799)  check("a_hblnk_before_800", 48'(hb_a), 48'h0);
      if (c == 800)  check("a_hblnk_at_800", {36'b0, hb_a, hc_a}, {36'b0, 1'b1, 11'd800});
      if (c == 839)  check("a_hsync_before_840", 48'(hs_a), 48'h0);
      if (c == 840)  check("a_hsync_at_840", 48'(hs_a), 48'h1);
      if (c == 967)  check("a_hsync_at_967", 48'(hs_a), 48'h1);
      if (c == 968)  check("a_hsync_off_968", 48'(hs_a), 48'h0);
      if (c == 3 * 1056) check("a_three_lines", {26'b0, vc_a, hc_a}, {26'b0, 11'd3, 11'd0});
      if (c == 6 * 1056)
        check("a_line_wrap_5_to_6", {24'b0, ls_a, fs_a, vc_a, hc_a},
              {24'b0, 1'b1, 1'b0, 11'd6, 11'd0});
      if (c == 6 * 1056 + 1) check("a_line_start_one_cycle", 48'(ls_a), 48'h0);
    end

    // Asynchronous reset mid-line on dut_a: outputs must clear before the next edge.
    #2;
    rst_a = 1'b0;
    t_a = 0;
    last_a = 0;
    #1;
    check("a_async_reset", obs_a, model_a());
    step(1'b1, 1'b1);
    rst_a = 1'b1;

    // dut_b: drive to last pixel of the frame, then stall 7 cycles.
    cnt = 0;
    while ((t_b % B_FRAME) != B_FRAME - 1 && cnt < 2 * B_FRAME) begin
      step(1'b1, 1'b1);
      cnt++;
    end
    check("b_reach_frame_end", 48'(t_b % B_FRAME), 48'(B_FRAME - 1));
    held = obs_b;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b0);
      check("b_stall_hold", obs_b, held);
    end
    step(1'b1, 1'b1);
    check("b_frame_wrap_pulses", {24'b0, ls_b, fs_b, vc_b, hc_b}, {24'b0, 1'b1, 1'b1, 22'b0});
    step(1'b1, 1'b1);
    check("b_frame_start_one_cycle", 48'(fs_b), 48'h0);

    // Four full frames: count sync/blank cycles and watch the 2-bit wrap.
    vs_cnt = 0; vb_cnt = 0; hs_cnt = 0; saw_wrap = 0; prev_fc = fc_b;
    for (int i = 0; i < 4 * B_FRAME; i++) begin
      step(1'b1, 1'b1);
      if (!vs_b) vs_cnt++;
      if (vb_b)  vb_cnt++;
      if (!hs_b) hs_cnt++;
      if (prev_fc == 2'd3 && fc_b == 2'd0) saw_wrap = 1;
      prev_fc = fc_b;
    end
    check("b_vsync_active_cycles", 48'(vs_cnt), 48'(4 * (B_VSE - B_VSS) * B_HT));
    check("b_vblnk_cycles", 48'(vb_cnt), 48'(4 * (B_VT - B_VP) * B_HT));
    check("b_hsync_active_cycles", 48'(hs_cnt), 48'(4 * (B_HSE - B_HSS) * B_VT));
    check("b_frame_cnt_wrap", 48'(saw_wrap), 48'h1);

    // Mid-frame reset on dut_b, then time the first frame_start.
    cnt = 0;
    while ((t_b % B_FRAME) != 6 * B_HT + 10 && cnt < 2 * B_FRAME) begin
      step(1'b1, 1'b1);
      cnt++;
    end
    #2;
    rst_b = 1'b0;
    t_b = 0;
    last_b = 0;
    #1;
    check("b_async_reset", obs_b, model_b());
    step(1'b1, 1'b1);
    rst_b = 1'b1;
    cnt = 0;
    do begin
      step(1'b1, 1'b1);
      cnt++;
    end while (!fs_b && cnt < 2 * B_FRAME);
    check("b_first_frame_start_delay", 48'(cnt), 48'(B_FRAME));

    // Random enable traffic on both instances.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(4) != 0, $urandom_range(1) != 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
